fifo_packet_reader: RTL and testbench

//  Read-side drain engine for the router's packet FIFO. Sits on the FIFO read

---
 rtl/fifo_packet_reader.sv | 121 ++++++++++++
 tb/tb_fifo_packet_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_packet_reader.sv
// Read-side drain engine: walks one FIFO entry unit by unit, streams the bytes
// over a valid/ready interface, then pops the entry with a single rinc pulse.
module fifo_packet_reader #(
  parameter int unsigned WIDTH     = 11,
  parameter int unsigned UWIDTH    = 8,
  parameter int unsigned PTR_IN_SZ = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rempty,
  input  logic [UWIDTH-1:0]    rdata,
  output logic                 rinc,
  output logic [PTR_IN_SZ-1:0] raddr_in,
  output logic [UWIDTH-1:0]    out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam logic [PTR_IN_SZ-1:0] LAST_IDX = PTR_IN_SZ'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, POP} state_e;

  state_e               state_q, state_d;
  logic [PTR_IN_SZ-1:0] idx_q, idx_d;
  logic [UWIDTH-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 rinc_q, rinc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fire_c;

  assign fire_c = valid_q & out_ready;

  // Next-state, datapath and unit-address decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    rinc_d   = 1'b0;
    raddr_in = idx_q;

    case (state_q)
      IDLE: begin
        raddr_in = '0;
        if (!rempty) state_d = FETCH;
      end
      FETCH: begin
        if (flush) begin
          state_d = POP;
        end else begin
          data_d  = rdata;
          valid_d = 1'b1;
          last_d  = (idx_q == LAST_IDX);
          state_d = SEND;
        end
      end
      SEND: begin
        // flush takes priority over a same-cycle handshake
        if (flush) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = POP;
        end else if (fire_c && !last_q) begin
          idx_d    = idx_q + PTR_IN_SZ'(1);
          raddr_in = idx_d;
          data_d   = rdata;
          last_d   = (idx_d == LAST_IDX);
        end else if (fire_c) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = POP;
        end
      end
      POP: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // rinc is high for exactly the single POP cycle
    rinc_d = (state_d == POP) && (state_q != POP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rinc_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      rinc_q  <= rinc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rinc      = rinc_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign pkt_count = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Bench for fifo_packet_reader: FIFO model feeding rdata, packet-level
// scoreboard of streamed bytes, pops and delivered-packet count.
module tb_fifo_packet_reader;

  localparam int unsigned WIDTH     = 11;
  localparam int unsigned UWIDTH    = 8;
  localparam int unsigned PTR_IN_SZ = 4;
  localparam int unsigned CNT_W     = 16;

  logic                 clk;
  logic                 rst;
  logic                 rempty;
  logic [UWIDTH-1:0]    rdata;
  logic                 rinc;
  logic [PTR_IN_SZ-1:0] raddr_in;
  logic [UWIDTH-1:0]    out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic                 flush;
  logic                 busy;
  logic [CNT_W-1:0]     pkt_count;

  fifo_packet_reader #(
    .WIDTH(WIDTH), .UWIDTH(UWIDTH), .PTR_IN_SZ(PTR_IN_SZ), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .raddr_in(raddr_in), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .flush(flush), .busy(busy),
    .pkt_count(pkt_count)
  );

  // FIFO model: 8 entries of WIDTH bytes, head pointer and occupancy
  logic [UWIDTH-1:0] mem [8][WIDTH];
  logic [2:0]        head;
  int                cnt;
  logic [3:0]        exp_idx;
  logic [CNT_W-1:0]  exp_pkts;
  int                checks;
  int                failures;
  logic              snap_fire, snap_flush, snap_valid, snap_last;
  logic [UWIDTH-1:0] snap_data;
  int                nv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rdata = 8'hEE;
    if (cnt > 0 && raddr_in < 4'(WIDTH)) rdata = mem[head][raddr_in];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_entry(input bit ramp);
    logic [2:0] w;
    w = head + 3'(cnt);
    for (int i = 0; i < int'(WIDTH); i++)
      mem[w][4'(i)] = ramp ? 8'(i) : 8'($urandom);
    cnt++;
    rempty = 1'b0;
  endtask

  // Settle what the previous clock edge did against the model
  task automatic process_prev();
    logic exp_rinc;
    exp_rinc = 1'b0;
    if (snap_fire) begin
      check_eq("fire_nonempty", 32'(cnt != 0), 32'd1);
      check_eq("data", 32'(snap_data), 32'(mem[head][exp_idx]));
      check_eq("last", 32'(snap_last), 32'(exp_idx == 4'(WIDTH - 1)));
      if (exp_idx == 4'(WIDTH - 1)) begin
        exp_pkts++;
        exp_rinc = 1'b1;
        exp_idx  = '0;
      end else begin
        exp_idx++;
      end
    end else if (snap_flush) begin
      exp_rinc = 1'b1;
      exp_idx  = '0;
      check_eq("flush_valid", 32'(out_valid), 32'd0);
    end else if (snap_valid) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", 32'(out_data), 32'(snap_data));
    end
    check_eq("rinc", 32'(rinc), 32'(exp_rinc));
    check_eq("pkt_count", 32'(pkt_count), 32'(exp_pkts));
    check_eq("raddr_range", 32'(raddr_in <= 4'(WIDTH - 1)), 32'd1);
    if (out_valid) check_eq("busy_valid", 32'(busy), 32'd1);
    if (rinc) begin
      check_eq("rinc_rempty", 32'(rempty), 32'd0);
      check_eq("pop_valid", 32'(out_valid), 32'd0);
      if (cnt > 0) begin
        head++;
        cnt--;
        rempty = (cnt == 0);
      end
    end
  endtask

  // fl_mode: 0 none, 1 flush at byte 4, 2 random flush, 3 flush forced (idle only)
  task automatic cycle(input bit rdy, input int fl_mode, input int push);
    logic fl;
    @(negedge clk);
    process_prev();
    if (push == 1) push_entry(1'b1);
    else if (push == 2) push_entry(1'b0);
    case (fl_mode)
      1:       fl = out_valid && (exp_idx == 4'd4);
      2:       fl = out_valid && (($urandom % 16) == 0);
      3:       fl = 1'b1;
      default: fl = 1'b0;
    endcase
    out_ready  = rdy;
    flush      = fl;
    snap_valid = out_valid;
    snap_data  = out_data;
    snap_last  = out_last;
    snap_flush = fl && out_valid;
    snap_fire  = out_valid && rdy && !fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    process_prev();
    rst = 1'b0;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_rinc", 32'(rinc), 32'd0);
    check_eq("rst_count", 32'(pkt_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    exp_idx    = '0;
    exp_pkts   = '0;
    snap_fire  = 1'b0;
    snap_flush = 1'b0;
    snap_valid = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; cnt = 0; head = '0; exp_idx = '0; exp_pkts = '0;
    snap_fire = 1'b0; snap_flush = 1'b0; snap_valid = 1'b0; snap_last = 1'b0;
    snap_data = '0; rempty = 1'b1; out_ready = 1'b0; flush = 1'b0; rst = 1'b1;

    // power-on reset
    do_reset();
    check_eq("rst_raddr", 32'(raddr_in), 32'd0);

    // single packet 0x00..0x0A, ready held high
    nv = 0;
    cycle(1'b1, 0, 1);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 0, 0);
      if (k == 0) check_eq("latency_fetch", 32'(out_valid), 32'd0);
      if (k == 1) check_eq("latency_valid", 32'(out_valid), 32'd1);
      nv += int'(out_valid);
    end
    check_eq("burst_len", 32'(nv), 32'd11);

    // ready toggling every cycle
    cycle(1'b0, 0, 1);
    for (int k = 0; k < 34; k++) cycle(1'(k % 2), 0, 0);

    // three entries back to back
    cycle(1'b1, 0, 2);
    cycle(1'b1, 0, 2);
    cycle(1'b1, 0, 2);
    for (int k = 0; k < 50; k++) cycle(1'b1, 0, 0);
    check_eq("three_drained", 32'(cnt), 32'd0);

    // flush after the fourth byte, next entry delivered from byte 0
    cycle(1'b1, 0, 2);
    cycle(1'b1, 0, 2);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1, 0);
    for (int k = 0; k < 20; k++) cycle(1'b1, 0, 0);
    check_eq("flush_drained", 32'(cnt), 32'd0);

    // reset mid-packet replays the same entry
    cycle(1'b1, 0, 1);
    for (int k = 0; k < 30 && exp_idx != 4'd5; k++) cycle(1'b1, 0, 0);
    check_eq("reached_byte5", 32'(exp_idx), 32'd5);
    do_reset();
    check_eq("entry_kept", 32'(cnt), 32'd1);
    for (int k = 0; k < 20; k++) cycle(1'b1, 0, 0);
    check_eq("replay_done", 32'(cnt), 32'd0);

    // empty FIFO with flush asserted: engine stays idle
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 3, 0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_valid", 32'(out_valid), 32'd0);
    end
    cycle(1'b1, 0, 0);

    // random traffic, stalls and flushes
    for (int k = 0; k < 3000; k++)
      cycle(1'(($urandom % 4) != 0), 2, (cnt < 7 && ($urandom % 10) == 0) ? 2 : 0);
    for (int k = 0; k < 120; k++) cycle(1'b1, 0, 0);
    check_eq("final_drained", 32'(cnt), 32'd0);
    check_eq("final_count", 32'(pkt_count), 32'(exp_pkts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
